// File: rtl/phase_timer_pkg.sv
// Shared types and default constants for the phase timer.
// The top file documents the optional PHASE_TIMER_WARN_EN build macro.
package phase_timer_pkg;

  typedef enum logic [1:0] {
    PT_IDLE,
    PT_RUN,
    PT_DONE
  } pt_state_t;

  // Default mask: counting enabled in controller states 1, 6 and 7.
  localparam logic [15:0] PT_ACTIVE_MASK_DEFAULT = 16'h00C2;
  localparam int          PT_TIMEOUT_DEFAULT     = 15;
  localparam int          PT_MASK_W              = 16;

  // A limit of zero selects the built-in timeout.
  function automatic logic [31:0] pt_limit_sel(input logic [31:0] lim, input logic [31:0] dflt);
    return (lim == 32'd0) ? dflt : lim;
  endfunction

endpackage

// File: rtl/phase_timer_tick_prescaler.sv
// Divides the system clock down to the count-tick rate.
// The tick strobe is combinational; the parent registers it alongside the count.
module tick_prescaler #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int              PW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]   LAST = PW'(DIV - 1);

  logic [PW-1:0] cnt_q;

  assign tick = en && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + PW'(1);
    end
  end

endmodule

// File: rtl/phase_timer.sv
// Per-phase countdown/countup timer driven by a self-generated seconds tick.
// Build macro PHASE_TIMER_WARN_EN adds the registered near-expiry warn output.
module phase_timer
  import phase_timer_pkg::*;
#(
  parameter int          CLK_HZ      = 50_000_000,
  parameter int          TICK_HZ     = 1,
  parameter int          STATE_W     = 4,
  parameter logic [15:0] ACTIVE_MASK = PT_ACTIVE_MASK_DEFAULT,
  parameter int          TIMEOUT     = PT_TIMEOUT_DEFAULT,
  parameter int          CNT_W       = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STATE_W-1:0] current_state,
  input  logic [STATE_W-1:0] next_state,
  input  logic               clear,
  input  logic               pause,
  input  logic               auto_reload,
  input  logic [CNT_W-1:0]   limit_i,
  output logic               tick,
  output logic [CNT_W-1:0]   count,
  output logic [CNT_W-1:0]   remaining,
  output logic               expired,
  output logic               finished,
  output logic               warn
);

  localparam int              DIV       = CLK_HZ / TICK_HZ;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  pt_state_t        state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] limit_q, limit_d;
  logic [CNT_W-1:0] count_inc;
  logic [CNT_W-1:0] limit_sel;
  logic             tick_q, tick_d;
  logic             expired_q, expired_d;
  logic             finished_q, finished_d;
  logic             enabled;
  logic             restart;
  logic             run_en;
  logic             pre_tick;
  logic [PT_MASK_W-1:0] state_hit;

  // Codes beyond the mask width never match, so they read as disabled.
  for (genvar gi = 0; gi < PT_MASK_W; gi++) begin : g_state_hit
    assign state_hit[gi] = (int'(current_state) == gi);
  end

  assign enabled   = |(state_hit & ACTIVE_MASK);
  assign restart   = clear || (current_state != next_state);
  assign run_en    = (state_q == PT_RUN) && enabled && !pause;
  assign count_inc = count_q + CNT_W'(1);
  assign limit_sel = CNT_W'(pt_limit_sel(32'(limit_i), 32'(TIMEOUT_C)));

  tick_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (restart || (state_q != PT_RUN)),
    .en   (run_en),
    .tick (pre_tick)
  );

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    limit_d    = limit_q;
    tick_d     = 1'b0;
    expired_d  = 1'b0;
    finished_d = finished_q;
    if (restart) begin
      state_d    = PT_IDLE;
      count_d    = '0;
      limit_d    = limit_sel;
      finished_d = 1'b0;
    end else begin
      case (state_q)
        PT_IDLE: begin
          if (enabled && !pause) state_d = PT_RUN;
        end
        PT_RUN: begin
          // Only reachable right after an auto-reload expiry; the prescaler
          // has just wrapped, so no tick can collide with the reload.
          if (count_q == limit_q) begin
            count_d = '0;
          end else if (pre_tick) begin
            tick_d  = 1'b1;
            count_d = count_inc;
            if (count_inc == limit_q) begin
              expired_d  = 1'b1;
              finished_d = 1'b1;
              if (!auto_reload) state_d = PT_DONE;
            end
          end
        end
        PT_DONE: begin
          count_d    = limit_q;
          finished_d = 1'b1;
        end
        default: state_d = PT_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= PT_IDLE;
      count_q    <= '0;
      limit_q    <= TIMEOUT_C;
      tick_q     <= 1'b0;
      expired_q  <= 1'b0;
      finished_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      limit_q    <= limit_d;
      tick_q     <= tick_d;
      expired_q  <= expired_d;
      finished_q <= finished_d;
    end
  end

`ifdef PHASE_TIMER_WARN_EN
  localparam logic [CNT_W-1:0] WARN_TICKS = CNT_W'(3);

  logic [CNT_W-1:0] rem_d;
  logic             warn_q, warn_d;

  // Evaluated on next-state values so warn lines up with the count it describes.
  assign rem_d  = limit_d - count_d;
  assign warn_d = (state_d == PT_RUN) && (rem_d != '0) && (rem_d <= WARN_TICKS);

  always_ff @(posedge clk) begin
    if (rst) begin
      warn_q <= 1'b0;
    end else begin
      warn_q <= warn_d;
    end
  end

  assign warn = warn_q;
`else
  assign warn = 1'b0;
`endif

  assign tick      = tick_q;
  assign count     = count_q;
  assign remaining = limit_q - count_q;
  assign expired   = expired_q;
  assign finished  = finished_q;

endmodule
